alu_sched: RTL
==============

Name: alu_sched

Overview:
- Shares the single 8-bit combinational ALU between NREQ requesters, e.g. the execute stage and the address/pointer unit.
- Arbitrates requests round-robin and drives the ALU opcode, enable and operand buses for exactly one cycle.
- Captures the result, derives status flags, and returns a held response with a valid/ready handshake.
- Also implements CMP (issued to the ALU as SUB, with writeback suppressed) and divide-by-zero trapping, which the ALU itself does not cover.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- W, 8, operand/result width; must match the ALU bus width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept, asserted only in IDLE, to the granted requester.
- req_opr  in  3*NREQ  opcode per requester: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, CMP=7.
- req_a  in  W*NREQ  operand A per requester.
- req_b  in  W*NREQ  operand B, or immediate, per requester.
- req_imm  in  NREQ  1 = route req_b onto the ALU direct (immediate) bus.
- rsp_valid  out  NREQ  one-hot response valid, to the requester that was served.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_data  out  W  result.
- rsp_flags  out  4  {E,C,N,Z}.
- rsp_wb  out  1  1 = requester writes rsp_data back; 0 for CMP and for a DIV error.
- alu_a  out  W  ALU A bus.
- alu_b  out  W  ALU B bus.
- alu_direct  out  W  ALU direct/immediate bus.
- alu_direct_en  out  1  select the direct bus as the ALU B input.
- alu_opr  out  3  ALU opcode.
- alu_en  out  1  ALU output enable; the ALU output is high-Z when low.
- alu_result  in  W  ALU output bus.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all outputs 0, including alu_en=0 so the ALU bus is released.
  - RR pointer last=NREQ-1, so requester 0 wins first.
  - Any in-flight operation is discarded with no response.
- States: IDLE -> EXEC -> RESP -> IDLE. Every operation takes exactly 3 cycles when rsp_ready is already high.
- IDLE:
  - Grant goes to the first requester with req_valid set, searching (last+1) mod NREQ upward.
  - req_ready[g]=1 combinationally in the same cycle.
  - On valid&ready: latch opr, a, b, imm and the index g; set last=g; go to EXEC.
  - No valid: stay in IDLE.
- EXEC (one cycle):
  - Drive alu_a=a and alu_opr = (opr==CMP ? SUB : opr).
  - If imm: alu_direct=b, alu_direct_en=1, alu_b=0. Otherwise: alu_b=b, alu_direct_en=0.
  - alu_en=1, except for DIV with b==0, where alu_en=0.
  - At the clock edge: register the result (sampled from alu_result) and the flags, then go to RESP.
- DIV with b==0: rsp_data=8'hFF, E=1, N=1, Z=0, C=0, rsp_wb=0.
- Flags for all other operations:
  - Z = (result==0); N = result[W-1].
  - C, ADD: carry out of a (W+1)-bit sum, computed inside the block.
  - C, SUB/CMP: borrow, i.e. a<b unsigned.
  - C, MUL: high W bits of the 2W-bit product are nonzero.
  - C, logic ops: 0.
  - E = 0.
- rsp_wb: 0 for CMP; 1 otherwise, except the DIV error above.
- RESP:
  - rsp_valid[g]=1; rsp_data, rsp_flags and rsp_wb are held stable until rsp_ready[g]=1.
  - On that edge: go to IDLE and clear rsp_valid.
  - rsp_ready on any other index is ignored.
- No new request is accepted outside IDLE. Requesters hold req_* stable while valid and not ready.
- A requester dropping req_valid before it is granted is legal and causes no side effects.
- alu_en is never high outside EXEC.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD..CMP) and flag bit indices (Z=0, N=1, C=2, E=3). The ALU is also refactored to use this package.
- One sub-module, rr_arbiter: parameter NREQ; inputs req, advance and rst_n; output one-hot grant; holds the round-robin pointer.
- Flag logic stays inline in alu_sched.

Test Plan:
- Req0 ADD a=8'hF0, b=8'h20, imm=0 -> alu_en high for exactly 1 cycle; rsp_data=8'h10; flags C=1, Z=0, N=0; rsp_wb=1; rsp_valid rises 2 cycles after accept.
- Req1 CMP a=5, b=5 -> alu_opr=1 during EXEC; rsp_data=0; Z=1, C=0; rsp_wb=0.
- Req0 DIV a=9, b=0 -> alu_en stays 0 throughout; rsp_data=8'hFF; E=1, N=1; rsp_wb=0.
- Both requesters valid continuously for 4 operations -> grant order 0,1,0,1; req_ready is never high outside IDLE.
- Req0 MUL a=16, b=16, imm=1 -> alu_direct_en=1 and alu_direct=16 in EXEC; rsp_data=0; C=1, Z=1. Hold rsp_ready low for 5 cycles -> response held stable throughout.
- Assert rst_n=0 during EXEC -> all outputs 0 asynchronously; no response issued; the next request goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and status flag bit indices shared by the ALU
// and alu_sched.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // Bit positions inside the 4-bit {E,C,N,Z} flag vector.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_E = 3;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered "last granted" pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> NREQ-1)
//   req        : per-requester request
//   advance    : move the pointer to the current grant (if any)
//   grant      : one-hot grant, searching upward from last+1
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] gidx;
    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sel = IW'((32'(last_q) + 32'd1 + i) % NREQ);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                gidx       = sel;
            end
        end
        last_d = (advance && found) ? gidx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= IW'(NREQ - 1);
        else        last_q <= last_d;
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one combinational ALU between NREQ requesters.
//   req_*      : request channel per requester (valid/ready, opcode, operands)
//   rsp_*      : held response (one-hot valid, data, {E,C,N,Z} flags, wb)
//   alu_*      : drive/return buses of the external ALU, active only in EXEC
// CMP is issued as SUB with writeback suppressed; DIV by zero is trapped here
// without enabling the ALU.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_opr,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_imm,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              rsp_wb,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [W-1:0]      alu_direct,
    output logic              alu_direct_en,
    output logic [2:0]        alu_opr,
    output logic              alu_en,
    input  logic [W-1:0]      alu_result
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    opr_q, opr_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          imm_q, imm_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  data_q, data_d;
    logic [3:0]    flags_q, flags_d;
    logic          wb_q, wb_d;

    logic [NREQ-1:0] grant;
    logic            in_idle;
    logic            div_err;
    logic [W:0]      sum;
    logic [2*W-1:0]  prod;

    assign in_idle = (state_q == IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (in_idle),
        .grant   (grant)
    );

    assign req_ready = (in_idle && rst_n) ? grant : '0;

    assign div_err = (opr_q == OP_DIV) && (b_q == '0);
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign prod    = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

    always_comb begin
        state_d = state_q;
        opr_d   = opr_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        idx_d   = idx_q;
        data_d  = data_q;
        flags_d = flags_q;
        wb_d    = wb_q;
        case (state_q)
            IDLE: begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (grant[i]) begin
                        opr_d   = req_opr[i*3 +: 3];
                        a_d     = req_a[i*W +: W];
                        b_d     = req_b[i*W +: W];
                        imm_d   = req_imm[i];
                        idx_d   = IW'(i);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                flags_d = '0;
                if (div_err) begin
                    data_d          = '1;
                    flags_d[FLAG_E] = 1'b1;
                    flags_d[FLAG_N] = 1'b1;
                    wb_d            = 1'b0;
                end else begin
                    data_d          = alu_result;
                    flags_d[FLAG_Z] = (alu_result == '0);
                    flags_d[FLAG_N] = alu_result[W-1];
                    case (opr_q)
                        OP_ADD:         flags_d[FLAG_C] = sum[W];
                        OP_SUB, OP_CMP: flags_d[FLAG_C] = (a_q < b_q);
                        OP_MUL:         flags_d[FLAG_C] = (prod[2*W-1:W] != '0);
                        default:        flags_d[FLAG_C] = 1'b0;
                    endcase
                    wb_d = (opr_q != OP_CMP);
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[idx_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            flags_q <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opr_q   <= opr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            wb_q    <= wb_d;
        end
    end

    // ALU buses are decoded from the EXEC state and the latched request only,
    // so they fall to zero asynchronously together with the state on reset.
    always_comb begin
        alu_a         = '0;
        alu_b         = '0;
        alu_direct    = '0;
        alu_direct_en = 1'b0;
        alu_opr       = '0;
        alu_en        = 1'b0;
        if (state_q == EXEC) begin
            alu_a         = a_q;
            alu_opr       = (opr_q == OP_CMP) ? OP_SUB : opr_q;
            alu_direct_en = imm_q;
            if (imm_q) alu_direct = b_q;
            else       alu_b      = b_q;
            alu_en        = !div_err;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[idx_q] = 1'b1;
    end

    assign rsp_data  = data_q;
    assign rsp_flags = flags_q;
    assign rsp_wb    = wb_q;

endmodule
